// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared router constants and scheduler types
package router_pkg;
   localparam int N_PORTS = 16;
   localparam int IDX_W   = 4;

   typedef enum logic {IDLE, LOCKED} sched_state_t;
   typedef logic [N_PORTS-1:0] port_vec_t;
endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - rotate-priority encoder: first request at or after ptr wins
module rr_pick
   import router_pkg::*;
(
   input  port_vec_t        req,
   input  logic [IDX_W-1:0] ptr,
   output port_vec_t        winner,
   output logic [IDX_W-1:0] winner_idx,
   output logic             any
);
   logic [2*N_PORTS-1:0] req_dbl;
   port_vec_t            rot;
   logic [IDX_W-1:0]     rot_idx;

   // rot[k] holds req[(ptr+k) mod N_PORTS], so the lowest set bit is the winner
   assign req_dbl = {req, req};
   assign rot     = req_dbl[ptr +: N_PORTS];

   always_comb begin
      rot_idx = '0;
      for (int k = N_PORTS - 1; k >= 0; k--) begin
         if (rot[k]) rot_idx = IDX_W'(k);
      end
   end

   assign any        = |req;
   assign winner_idx = rot_idx + ptr;
   assign winner     = any ? (port_vec_t'(1'b1) << winner_idx) : '0;
endmodule

// File: rtl/rr_packet_scheduler.sv
// rtl/rr_packet_scheduler.sv - round-robin output-port scheduler with packet lock and stall watchdog
module rr_packet_scheduler #(
   parameter int N_PORTS = 16,
   parameter int IDX_W   = 4,
   parameter int TIMEOUT = 255
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [N_PORTS-1:0] request,
   input  logic [N_PORTS-1:0] last,
   input  logic               out_ready,
   output logic [N_PORTS-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               fire,
   output logic               busy,
   output logic               timeout_err
);
   import router_pkg::*;

   localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

   sched_state_t       state, state_nxt;
   logic [IDX_W-1:0]   ptr, ptr_nxt, idx_nxt;
   logic [N_PORTS-1:0] grant_nxt, pick_winner;
   logic [IDX_W-1:0]   pick_idx;
   logic               pick_any;
   logic [7:0]         wd, wd_nxt;
   logic               terr_nxt, withdrawn, eop, wd_expired;

   rr_pick u_pick (
      .req        (request),
      .ptr        (ptr),
      .winner     (pick_winner),
      .winner_idx (pick_idx),
      .any        (pick_any)
   );

   assign fire       = out_ready & |(grant & request);
   assign busy       = (state == LOCKED);
   assign withdrawn  = ~request[grant_idx];
   assign eop        = fire & last[grant_idx];
   assign wd_expired = ~fire & (wd == WD_LAST);

   always_comb begin
      state_nxt = state;
      grant_nxt = grant;
      idx_nxt   = grant_idx;
      ptr_nxt   = ptr;
      wd_nxt    = wd;
      terr_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (pick_any) begin
               grant_nxt = pick_winner;
               idx_nxt   = pick_idx;
               wd_nxt    = '0;
               state_nxt = LOCKED;
            end
         end
         LOCKED: begin
            if (withdrawn || eop || wd_expired) begin
               grant_nxt = '0;
               ptr_nxt   = grant_idx + 1'b1;
               state_nxt = IDLE;
               // withdrawal outranks the watchdog, so it never reports an error
               terr_nxt  = ~withdrawn & ~eop & wd_expired;
            end else if (fire) begin
               wd_nxt = '0;
            end else if (wd != 8'hFF) begin
               wd_nxt = wd + 8'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         grant       <= '0;
         grant_idx   <= '0;
         ptr         <= '0;
         wd          <= '0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_nxt;
         grant       <= grant_nxt;
         grant_idx   <= idx_nxt;
         ptr         <= ptr_nxt;
         wd          <= wd_nxt;
         timeout_err <= terr_nxt;
      end
   end
endmodule

// File: tb/tb_rr_packet_scheduler.sv
// tb/tb_rr_packet_scheduler.sv - self-checking bench for rr_packet_scheduler
module tb_rr_packet_scheduler;
   localparam int TIMEOUT = 255;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [15:0] request = '0;
   logic [15:0] last = '0;
   logic        out_ready = 1'b0;
   logic [15:0] grant;
   logic [3:0]  grant_idx;
   logic        fire, busy, timeout_err;

   int n_pass = 0;
   int n_total = 0;

   rr_packet_scheduler #(.N_PORTS(16), .IDX_W(4), .TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .request     (request),
      .last        (last),
      .out_ready   (out_ready),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .fire        (fire),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
   endtask

   // Reference model: owner index, lock flag, search start, stall counter
   bit m_locked = 1'b0;
   int m_idx = 0;
   int m_last_idx = 0;
   int m_ptr = 0;
   int m_stall = 0;
   bit m_terr = 1'b0;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_locked = 1'b0; m_idx = 0; m_last_idx = 0; m_ptr = 0; m_stall = 0; m_terr = 1'b0;
      end else begin
         bit f, found;
         m_terr = 1'b0;
         if (!m_locked) begin
            found = 1'b0;
            for (int k = 0; k < 16; k++) begin
               if (!found && request[(m_ptr + k) % 16]) begin
                  found = 1'b1;
                  m_idx = (m_ptr + k) % 16;
               end
            end
            if (found) begin
               m_locked = 1'b1; m_stall = 0; m_last_idx = m_idx;
            end
         end else begin
            f = out_ready && request[m_idx];
            if (!request[m_idx] || (f && last[m_idx])) begin
               m_locked = 1'b0; m_ptr = (m_idx + 1) % 16;
            end else if (!f && m_stall == TIMEOUT - 1) begin
               m_locked = 1'b0; m_ptr = (m_idx + 1) % 16; m_terr = 1'b1;
            end else if (f) begin
               m_stall = 0;
            end else if (m_stall < 255) begin
               m_stall++;
            end
         end
      end
   end

   always @(negedge clk) begin
      logic [15:0] eg;
      eg = m_locked ? (16'h1 << m_idx) : 16'h0;
      chk("grant", grant, eg);
      chk("grant_idx", grant_idx, m_last_idx[3:0]);
      chk("busy", busy, m_locked);
      chk("timeout_err", timeout_err, m_terr);
      chk("fire", fire, m_locked && out_ready && request[m_idx]);
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   initial begin
      int n;
      logic [15:0] exp_g;
      repeat (3) step();
      chk("reset_grant", grant, 16'h0);
      chk("reset_busy", busy, 1'b0);
      chk("reset_terr", timeout_err, 1'b0);
      chk("reset_idx", grant_idx, 4'h0);

      // 1: all requesting, 2-flit packets, full rotation plus wrap
      reset_n = 1'b1;
      request = 16'hFFFF;
      out_ready = 1'b1;
      step();
      for (int i = 0; i < 17; i++) begin
         if (i > 0) step();
         exp_g = 16'h1 << (i % 16);
         chk("t1_grant", grant, exp_g);
         step();
         last = 16'hFFFF;
         step();
         chk("t1_bubble", grant, 16'h0);
         last = 16'h0;
      end

      // 2: ptr=1, two requesters around the wrap
      request = 16'h0011;
      last = 16'hFFFF;
      step();
      chk("t2_first", grant, 16'h0010);
      step();
      chk("t2_single_flit_release", grant, 16'h0);
      step();
      chk("t2_wrap", grant, 16'h0001);
      step();
      request = 16'h0;
      last = 16'h0;

      // 3: 4-flit packet with toggling out_ready; input 9 intrudes mid-packet
      request = 16'h0008;
      step();
      for (int c = 0; c < 7; c++) begin
         chk("t3_hold", grant, 16'h0008);
         out_ready = (c % 2 == 0);
         last = (c == 6) ? 16'hFFFF : 16'h0;
         if (c == 3) request = request | 16'h0200;
         step();
      end
      chk("t3_release", grant, 16'h0);
      last = 16'h0;
      step();
      chk("t3_next", grant, 16'h0200);
      request = 16'h0;
      step();

      // 4: stalled packet on input 7 hits the watchdog
      request = 16'h0080;
      out_ready = 1'b0;
      step();
      n = 0;
      while (grant == 16'h0080 && n < 300) begin
         n++;
         step();
      end
      chk("t4_locked_cycles", n, 255);
      chk("t4_terr_pulse", timeout_err, 1'b1);
      request = 16'h0181;
      step();
      chk("t4_terr_clear", timeout_err, 1'b0);
      chk("t4_next_from_8", grant, 16'h0100);
      request = 16'h0;
      step();

      // 5: withdrawal mid-packet on input 2
      request = 16'h0004;
      out_ready = 1'b1;
      step();
      chk("t5_grant", grant, 16'h0004);
      step();
      request = 16'h001B;
      step();
      chk("t5_release", grant, 16'h0);
      chk("t5_no_err", timeout_err, 1'b0);
      step();
      chk("t5_ptr3", grant, 16'h0008);
      request = 16'h0;
      step();

      // 6: asynchronous reset mid-packet
      request = 16'h0020;
      step();
      chk("t6_grant", grant, 16'h0020);
      step();
      #1 reset_n = 1'b0;
      #1;
      chk("t6_async_grant", grant, 16'h0);
      chk("t6_async_busy", busy, 1'b0);
      chk("t6_async_idx", grant_idx, 4'h0);
      step();
      step();
      reset_n = 1'b1;
      request = 16'h0100;
      step();
      chk("t6_after_reset", grant, 16'h0100);
      request = 16'h0;
      step();
      step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
